// File: rtl/ifu_pkg.sv
// Shared IFU types and widths for the memory-port arbiter.
package ifu_pkg;

    localparam int unsigned IFU_TAG_W   = 27;
    localparam int unsigned IFU_LINE_W  = 128;
    localparam int unsigned IFU_TIMEOUT = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FILL  = 2'd3
    } t_arb_state;

    typedef enum logic {
        SRC_MISS = 1'b0,
        SRC_PF   = 1'b1
    } t_fill_src;

endpackage

// File: rtl/ifu_arb_timer.sv
// Response timeout counter: clears on issue, counts WAIT cycles, saturates at TIMEOUT-1.
module ifu_arb_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned   CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // expire tracks the counter value it will hold next cycle
        expire_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/ifu_mem_arb.sv
// Shares the IFU memory read port between demand misses and the next-line prefetcher.
// One request in flight; a demand miss on the in-flight prefetch tag merges into it.
module ifu_mem_arb
    import ifu_pkg::*;
#(
    parameter int unsigned TAG_W   = IFU_TAG_W,
    parameter int unsigned LINE_W  = IFU_LINE_W,
    parameter int unsigned TIMEOUT = IFU_TIMEOUT
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic [TAG_W-1:0]  miss_reqTagIn,
    input  logic              miss_reqValidIn,
    output logic              miss_reqReadyOut,
    input  logic [TAG_W-1:0]  pf_reqTagIn,
    input  logic              pf_reqValidIn,
    output logic              pf_reqReadyOut,
    output logic [TAG_W-1:0]  mem_reqTagOut,
    output logic              mem_reqValidOut,
    input  logic              mem_reqReadyIn,
    input  logic [TAG_W-1:0]  mem_rspTagIn,
    input  logic [LINE_W-1:0] mem_rspLineIn,
    input  logic              mem_rspValidIn,
    output logic [TAG_W-1:0]  fill_tagOut,
    output logic [LINE_W-1:0] fill_lineOut,
    output logic              fill_validOut,
    output logic              fill_srcOut,
    output logic              retryOut,
    output logic              staleOut
);

    t_arb_state        state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    t_fill_src         src_q, src_d;
    logic              mem_valid_q, mem_valid_d;
    logic [TAG_W-1:0]  mem_tag_q, mem_tag_d;
    logic              fill_valid_q, fill_valid_d;
    logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    t_fill_src         fill_src_q, fill_src_d;
    logic              retry_q, retry_d;
    logic              stale_q, stale_d;
    logic              miss_ready_c, pf_ready_c;
    logic              tmr_clr, tmr_en, tmr_expire;
    logic              rsp_hit, merge;

    ifu_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i    (Clock),
        .rst_ni   (Rst),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    assign rsp_hit = mem_rspValidIn && (mem_rspTagIn == tag_q);
    // FILL is excluded: its fill_srcOut is already registered, so a late miss waits for IDLE
    assign merge   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (src_q == SRC_PF)
                     && miss_reqValidIn && (miss_reqTagIn == tag_q);

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        src_d        = src_q;
        miss_ready_c = 1'b0;
        pf_ready_c   = 1'b0;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        fill_valid_d = 1'b0;
        fill_tag_d   = '0;
        fill_line_d  = '0;
        fill_src_d   = SRC_MISS;
        retry_d      = 1'b0;
        stale_d      = 1'b0;

        if (merge) begin
            miss_ready_c = 1'b1;
            src_d        = SRC_MISS;
        end

        case (state_q)
            S_IDLE: begin
                miss_ready_c = miss_reqValidIn;
                pf_ready_c   = pf_reqValidIn && !miss_reqValidIn;
                if (miss_reqValidIn) begin
                    tag_d   = miss_reqTagIn;
                    src_d   = SRC_MISS;
                    state_d = S_ISSUE;
                end else if (pf_reqValidIn) begin
                    tag_d   = pf_reqTagIn;
                    src_d   = SRC_PF;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_reqReadyIn) begin
                    tmr_clr = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmr_en = 1'b1;
                // a matching response beats a same-cycle timeout
                if (rsp_hit) begin
                    fill_valid_d = 1'b1;
                    fill_tag_d   = tag_q;
                    fill_line_d  = mem_rspLineIn;
                    fill_src_d   = src_d;
                    state_d      = S_FILL;
                end else begin
                    stale_d = mem_rspValidIn;
                    if (tmr_expire) begin
                        retry_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_valid_d = (state_d == S_ISSUE);
        mem_tag_d   = mem_valid_d ? tag_d : '0;
    end

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            src_q        <= SRC_MISS;
            mem_valid_q  <= 1'b0;
            mem_tag_q    <= '0;
            fill_valid_q <= 1'b0;
            fill_tag_q   <= '0;
            fill_line_q  <= '0;
            fill_src_q   <= SRC_MISS;
            retry_q      <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            src_q        <= src_d;
            mem_valid_q  <= mem_valid_d;
            mem_tag_q    <= mem_tag_d;
            fill_valid_q <= fill_valid_d;
            fill_tag_q   <= fill_tag_d;
            fill_line_q  <= fill_line_d;
            fill_src_q   <= fill_src_d;
            retry_q      <= retry_d;
            stale_q      <= stale_d;
        end
    end

    assign miss_reqReadyOut = miss_ready_c;
    assign pf_reqReadyOut   = pf_ready_c;
    assign mem_reqValidOut  = mem_valid_q;
    assign mem_reqTagOut    = mem_tag_q;
    assign fill_validOut    = fill_valid_q;
    assign fill_tagOut      = fill_tag_q;
    assign fill_lineOut     = fill_line_q;
    assign fill_srcOut      = fill_src_q;
    assign retryOut         = retry_q;
    assign staleOut         = stale_q;

endmodule

// File: tb/tb_ifu_mem_arb.sv
// Bench for ifu_mem_arb: directed scenarios plus a randomized run against a transaction-level model.
module tb_ifu_mem_arb;

    localparam int unsigned TW = 27;
    localparam int unsigned LW = 128;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          rst;
    logic [TW-1:0] miss_tag, pf_tag, rsp_tag;
    logic          miss_v, pf_v, mem_rdy, rsp_v;
    logic [LW-1:0] rsp_line;
    logic          miss_rdy, pf_rdy, mem_v, fill_v, fill_src, retry, stale;
    logic [TW-1:0] mem_tag, fill_tag;
    logic [LW-1:0] fill_line;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rand_mode = 0;

    typedef struct {
        logic [TW-1:0] tag;
        int            due;
    } rsp_t;
    rsp_t rq[$];

    // model: pending request and the registered outputs it predicts for next cycle
    int            m_stage;     // 0 free, 1 requesting, 2 awaiting response, 3 delivering
    logic [TW-1:0] m_tag;
    logic          m_src;
    int            m_deadline;
    logic          ex_mem_v, ex_fill_v, ex_fill_src, ex_retry, ex_stale;
    logic [TW-1:0] ex_mem_tag, ex_fill_tag;
    logic [LW-1:0] ex_fill_line;

    ifu_mem_arb #(.TAG_W(TW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .Clock            (clk),
        .Rst              (rst),
        .miss_reqTagIn    (miss_tag),
        .miss_reqValidIn  (miss_v),
        .miss_reqReadyOut (miss_rdy),
        .pf_reqTagIn      (pf_tag),
        .pf_reqValidIn    (pf_v),
        .pf_reqReadyOut   (pf_rdy),
        .mem_reqTagOut    (mem_tag),
        .mem_reqValidOut  (mem_v),
        .mem_reqReadyIn   (mem_rdy),
        .mem_rspTagIn     (rsp_tag),
        .mem_rspLineIn    (rsp_line),
        .mem_rspValidIn   (rsp_v),
        .fill_tagOut      (fill_tag),
        .fill_lineOut     (fill_line),
        .fill_validOut    (fill_v),
        .fill_srcOut      (fill_src),
        .retryOut         (retry),
        .staleOut         (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // compare every output against the model, then advance the model
    always @(negedge clk) begin : compare
        logic mrg, e_mrdy, e_prdy;
        mrg    = 1'b0;
        e_mrdy = 1'b0;
        e_prdy = 1'b0;
        if (!rst) begin
            m_stage = 0; m_tag = '0; m_src = 1'b0; m_deadline = 0;
            ex_mem_v = 1'b0; ex_mem_tag = '0; ex_fill_v = 1'b0; ex_fill_tag = '0;
            ex_fill_line = '0; ex_fill_src = 1'b0; ex_retry = 1'b0; ex_stale = 1'b0;
        end else begin
            mrg    = (m_stage == 1 || m_stage == 2) && m_src && miss_v && (miss_tag == m_tag);
            e_mrdy = miss_v && (m_stage == 0 || mrg);
            e_prdy = pf_v && !miss_v && (m_stage == 0);
        end
        chk("m_miss_ready", LW'(miss_rdy), LW'(e_mrdy));
        chk("m_pf_ready",   LW'(pf_rdy),   LW'(e_prdy));
        chk("m_mem_valid",  LW'(mem_v),    LW'(ex_mem_v));
        chk("m_mem_tag",    LW'(mem_tag),  LW'(ex_mem_tag));
        chk("m_fill_valid", LW'(fill_v),   LW'(ex_fill_v));
        chk("m_fill_tag",   LW'(fill_tag), LW'(ex_fill_tag));
        chk("m_fill_line",  fill_line,     ex_fill_line);
        chk("m_fill_src",   LW'(fill_src), LW'(ex_fill_src));
        chk("m_retry",      LW'(retry),    LW'(ex_retry));
        chk("m_stale",      LW'(stale),    LW'(ex_stale));
        if (rst) begin
            ex_fill_v = 1'b0; ex_fill_tag = '0; ex_fill_line = '0; ex_fill_src = 1'b0;
            ex_retry = 1'b0; ex_stale = 1'b0;
            if (mrg) m_src = 1'b0;
            case (m_stage)
                0: begin
                    if (miss_v) begin
                        m_tag = miss_tag; m_src = 1'b0; m_stage = 1;
                    end else if (pf_v) begin
                        m_tag = pf_tag; m_src = 1'b1; m_stage = 1;
                    end
                end
                1: if (mem_rdy) begin
                    m_stage    = 2;
                    m_deadline = cyc + int'(TO);
                end
                2: begin
                    if (rsp_v && rsp_tag == m_tag) begin
                        ex_fill_v = 1'b1; ex_fill_tag = m_tag;
                        ex_fill_line = rsp_line; ex_fill_src = m_src;
                        m_stage = 3;
                    end else begin
                        ex_stale = rsp_v;
                        if (cyc == m_deadline) begin
                            ex_retry = 1'b1;
                            m_stage  = 1;
                        end
                    end
                end
                default: m_stage = 0;
            endcase
            ex_mem_v   = (m_stage == 1);
            ex_mem_tag = ex_mem_v ? m_tag : '0;
        end
        if (rand_mode && rst && mem_v && mem_rdy && ($urandom_range(0, 7) != 0))
            rq.push_back('{tag: mem_tag, due: cyc + int'($urandom_range(1, 10))});
        cyc++;
    end

    task automatic drive(input logic mv, input logic [TW-1:0] mt, input logic pv,
                         input logic [TW-1:0] pt, input logic mr, input logic rv,
                         input logic [TW-1:0] rt, input logic [LW-1:0] rl);
        @(posedge clk);
        #2;
        miss_v = mv; miss_tag = mt; pf_v = pv; pf_tag = pt;
        mem_rdy = mr; rsp_v = rv; rsp_tag = rt; rsp_line = rl;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    localparam logic [LW-1:0] L_DB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [LW-1:0] L_2  = 128'h2222_0000_0000_0000_0000_0000_0000_2222;
    localparam logic [LW-1:0] L_3  = 128'h3333_0000_0000_0000_0000_0000_0000_3333;
    localparam logic [LW-1:0] L_4  = 128'h4444_0000_0000_0000_0000_0000_0000_4444;
    localparam logic [LW-1:0] L_5  = 128'h5555_0000_0000_0000_0000_0000_0000_5555;
    localparam logic [LW-1:0] L_9  = 128'h9999_0000_0000_0000_0000_0000_0000_9999;

    initial begin
        rst = 1'b0;
        miss_v = 1'b0; miss_tag = '0; pf_v = 1'b0; pf_tag = '0;
        mem_rdy = 1'b0; rsp_v = 1'b0; rsp_tag = '0; rsp_line = '0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_mem_valid", LW'(mem_v), LW'(0));
        chk("rst_fill_valid", LW'(fill_v), LW'(0));
        @(posedge clk); #2; rst = 1'b1;

        // 1: plain miss, fill four cycles after accept
        drive(1'b1, TW'(1), 1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("t1_miss_ready", LW'(miss_rdy), LW'(1));
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("t1_mem_valid", LW'(mem_v), LW'(1));
        chk("t1_mem_tag", LW'(mem_tag), LW'(1));
        idle();
        chk("t1_mem_valid_drop", LW'(mem_v), LW'(0));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, TW'(1), L_DB);
        chk("t1_no_early_fill", LW'(fill_v), LW'(0));
        idle();
        chk("t1_fill_valid", LW'(fill_v), LW'(1));
        chk("t1_fill_src", LW'(fill_src), LW'(0));
        chk("t1_fill_line", fill_line, L_DB);
        chk("t1_fill_tag", LW'(fill_tag), LW'(1));
        idle();
        chk("t1_fill_one_cycle", LW'(fill_v), LW'(0));

        // 2: miss beats same-cycle prefetch, prefetch taken in next IDLE
        drive(1'b1, TW'(2), 1'b1, TW'(3), 1'b0, 1'b0, '0, '0);
        chk("t2_miss_ready", LW'(miss_rdy), LW'(1));
        chk("t2_pf_blocked", LW'(pf_rdy), LW'(0));
        drive(1'b0, '0, 1'b1, TW'(3), 1'b1, 1'b0, '0, '0);
        chk("t2_pf_busy", LW'(pf_rdy), LW'(0));
        drive(1'b0, '0, 1'b1, TW'(3), 1'b0, 1'b1, TW'(2), L_2);
        drive(1'b0, '0, 1'b1, TW'(3), 1'b0, 1'b0, '0, '0);
        chk("t2_fill2", LW'(fill_v), LW'(1));
        chk("t2_pf_in_fill", LW'(pf_rdy), LW'(0));
        drive(1'b0, '0, 1'b1, TW'(3), 1'b0, 1'b0, '0, '0);
        chk("t2_pf_accept", LW'(pf_rdy), LW'(1));
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("t2_mem_tag3", LW'(mem_tag), LW'(3));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, TW'(3), L_3);
        idle();
        chk("t2_fill3_src", LW'(fill_src), LW'(1));
        chk("t2_fill3_tag", LW'(fill_tag), LW'(3));

        // 3: miss merges into in-flight prefetch
        drive(1'b0, '0, 1'b1, TW'(4), 1'b0, 1'b0, '0, '0);
        chk("t3_pf_accept", LW'(pf_rdy), LW'(1));
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        drive(1'b1, TW'(4), 1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("t3_merge_ready", LW'(miss_rdy), LW'(1));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, TW'(4), L_4);
        chk("t3_no_second_req", LW'(mem_v), LW'(0));
        idle();
        chk("t3_fill", LW'(fill_v), LW'(1));
        chk("t3_fill_src", LW'(fill_src), LW'(0));
        chk("t3_fill_tag", LW'(fill_tag), LW'(4));

        // 4: mismatched response is dropped
        drive(1'b1, TW'(5), 1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, TW'(9), L_9);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, TW'(5), L_5);
        chk("t4_stale", LW'(stale), LW'(1));
        chk("t4_no_fill", LW'(fill_v), LW'(0));
        idle();
        chk("t4_fill", LW'(fill_v), LW'(1));
        chk("t4_fill_line", fill_line, L_5);
        chk("t4_stale_clear", LW'(stale), LW'(0));

        // 5: timeout re-issues the same tag eight cycles into WAIT
        drive(1'b1, TW'(6), 1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            idle();
            chk("t5_no_retry_yet", LW'(retry), LW'(0));
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        chk("t5_retry", LW'(retry), LW'(1));
        chk("t5_reissue", LW'(mem_v), LW'(1));
        chk("t5_reissue_tag", LW'(mem_tag), LW'(6));
        idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, TW'(6), L_DB);
        idle();
        chk("t5_fill", LW'(fill_v), LW'(1));

        // 6: reset during WAIT abandons the request
        drive(1'b1, TW'(7), 1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        idle();
        @(posedge clk); #2;
        rst = 1'b0; mem_rdy = 1'b0;
        #2;
        chk("t6_rst_mem_valid", LW'(mem_v), LW'(0));
        chk("t6_rst_fill", LW'(fill_v), LW'(0));
        chk("t6_rst_retry", LW'(retry), LW'(0));
        chk("t6_rst_stale", LW'(stale), LW'(0));
        @(posedge clk); #2;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, TW'(7), L_DB);
        idle();
        chk("t6_no_fill", LW'(fill_v), LW'(0));
        chk("t6_no_stale", LW'(stale), LW'(0));
        chk("t6_no_req", LW'(mem_v), LW'(0));

        // randomized traffic with a responding memory
        rq.delete();
        rand_mode = 1;
        for (int n = 0; n < 4000; n++) begin
            int idx;
            @(posedge clk);
            #2;
            miss_v   = ($urandom_range(0, 3) == 0);
            miss_tag = TW'($urandom_range(0, 5));
            pf_v     = ($urandom_range(0, 2) == 0);
            pf_tag   = TW'($urandom_range(0, 5));
            mem_rdy  = ($urandom_range(0, 9) < 6);
            rsp_v = 1'b0; rsp_tag = '0; rsp_line = '0;
            idx = -1;
            foreach (rq[i]) if (idx < 0 && rq[i].due <= cyc) idx = i;
            if (idx >= 0) begin
                rsp_v    = 1'b1;
                rsp_tag  = rq[idx].tag;
                rsp_line = {$urandom(), $urandom(), $urandom(), $urandom()};
                rq.delete(idx);
            end else if ($urandom_range(0, 19) == 0) begin
                rsp_v    = 1'b1;
                rsp_tag  = TW'($urandom_range(0, 7));
                rsp_line = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        rand_mode = 0;
        repeat (20) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
